// File: rtl/i2c_master_core.sv
// i2c_master_core
//   Byte-oriented I2C master. Runs one transaction per go rising edge:
//   START, 7-bit address + R/W, 1-4 data bytes, STOP. Open-drain pins are
//   driven through output enables (1 = pull low). No clock stretching and
//   no arbitration.
// Ports:
//   PCLK, PRESETn   clock, asynchronous active-low reset
//   i2c_con1        [0] go, [1] rw (1=read), [3:2] byte count - 1
//   i2c_con2        [6:0] slave address
//   Din             write data, byte 0 (Din[7:0]) sent first
//   sda_i           SDA pad input
//   Dout            read data, byte k in Dout[8k+7:8k]
//   ready           idle and able to accept a transaction
//   i2c_stat        [0] busy, [1] addr_nack, [2] data_nack, [7] done
//   scl_oe, sda_oe  1 = pull line low, 0 = release
module i2c_master_core #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [7:0]  i2c_con1,
  input  logic [7:0]  i2c_con2,
  input  logic [31:0] Din,
  input  logic        sda_i,
  output logic [31:0] Dout,
  output logic        ready,
  output logic [7:0]  i2c_stat,
  output logic        scl_oe,
  output logic        sda_oe
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WBYTE,
    S_WACK, S_RBYTE, S_RACK, S_STOP, S_DONE
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic        r_go_d;
  logic [7:0]  r_div;
  logic [1:0]  r_ph;
  logic [2:0]  r_bit;
  logic [1:0]  r_idx;
  logic        r_rw;
  logic [1:0]  r_cnt;
  logic [6:0]  r_addr;
  logic [31:0] r_din;
  logic [31:0] r_dout;
  logic        r_ack;
  logic        r_ready, r_busy, r_anack, r_dnack, r_done;

  logic        w_launch, w_active, w_tick, w_bitend, w_last;
  logic [2:0]  w_bsel;
  logic [4:0]  w_bofs;
  logic [7:0]  w_addr_byte, w_wbyte;
  logic        w_scl_oe, w_sda_oe;
  logic        w_unused_bits;

  assign w_unused_bits = ^{i2c_con1[7:4], i2c_con2[7]};

  assign w_launch    = (r_state == S_IDLE) && i2c_con1[0] && !r_go_d;
  assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_tick      = w_active && (r_div == DIV_MAX);
  assign w_bitend    = w_tick && (r_ph == 2'd3);
  assign w_last      = (r_idx == r_cnt);
  assign w_bsel      = 3'd7 - r_bit;
  assign w_bofs      = {r_idx, 3'b000};
  assign w_addr_byte = {r_addr, r_rw};
  assign w_wbyte     = r_din[w_bofs +: 8];

  // Pin enables are a pure decode of registered state/phase, so they only
  // move on phase boundaries and drop to zero the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    w_scl_oe    = 1'b0;
    w_sda_oe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = S_START;
      end
      S_START: begin
        // q0 idle bus, q1 SDA falls with SCL high, q2-q3 SCL low
        w_scl_oe = r_ph[1];
        w_sda_oe = (r_ph != 2'd0);
        if (w_bitend) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_scl_oe = !r_ph[1];
        w_sda_oe = !w_addr_byte[w_bsel];
        if (w_bitend && (r_bit == 3'd7)) w_state_nxt = S_AACK;
      end
      S_AACK: begin
        w_scl_oe = !r_ph[1];
        if (w_bitend) begin
          if (r_ack)     w_state_nxt = S_STOP;
          else if (r_rw) w_state_nxt = S_RBYTE;
          else           w_state_nxt = S_WBYTE;
        end
      end
      S_WBYTE: begin
        w_scl_oe = !r_ph[1];
        w_sda_oe = !w_wbyte[w_bsel];
        if (w_bitend && (r_bit == 3'd7)) w_state_nxt = S_WACK;
      end
      S_WACK: begin
        w_scl_oe = !r_ph[1];
        if (w_bitend) w_state_nxt = (r_ack || w_last) ? S_STOP : S_WBYTE;
      end
      S_RBYTE: begin
        w_scl_oe = !r_ph[1];
        if (w_bitend && (r_bit == 3'd7)) w_state_nxt = S_RACK;
      end
      S_RACK: begin
        // ACK every byte but the last, which is NACKed to end the read
        w_scl_oe = !r_ph[1];
        w_sda_oe = !w_last;
        if (w_bitend) w_state_nxt = w_last ? S_STOP : S_RBYTE;
      end
      S_STOP: begin
        // q0-q1 both low, q2 SCL released, q3 SDA rises with SCL high
        w_scl_oe = !r_ph[1];
        w_sda_oe = (r_ph != 2'd3);
        if (w_bitend) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_go_d  <= 1'b0;
      r_div   <= '0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_rw    <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_ack   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_anack <= 1'b0;
      r_dnack <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_go_d  <= i2c_con1[0];
      if (w_launch) begin
        r_rw    <= i2c_con1[1];
        r_cnt   <= i2c_con1[3:2];
        r_addr  <= i2c_con2[6:0];
        r_din   <= Din;
        r_div   <= '0;
        r_ph    <= '0;
        r_bit   <= '0;
        r_idx   <= '0;
        r_busy  <= 1'b1;
        r_ready <= 1'b0;
        r_anack <= 1'b0;
        r_dnack <= 1'b0;
        r_done  <= 1'b0;
        if (i2c_con1[1]) r_dout <= '0;
      end else if (w_active) begin
        if (w_tick) begin
          r_div <= '0;
          r_ph  <= r_ph + 2'd1;
          // end of q2: SCL has been high for a full quarter
          if (r_ph == 2'd2) begin
            r_ack <= sda_i;
            if (r_state == S_RBYTE) r_dout[w_bofs +: 8] <= {r_dout[w_bofs +: 7], sda_i};
          end
          if (r_ph == 2'd3) begin
            case (r_state)
              S_ADDR, S_WBYTE, S_RBYTE: r_bit <= r_bit + 3'd1;
              S_AACK: r_anack <= r_ack;
              S_WACK: begin
                if (r_ack)        r_dnack <= 1'b1;
                else if (!w_last) r_idx   <= r_idx + 2'd1;
              end
              S_RACK: begin
                if (!w_last) r_idx <= r_idx + 2'd1;
              end
              default: ;
            endcase
          end
        end else begin
          r_div <= r_div + 8'd1;
        end
      end else if (r_state == S_DONE) begin
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_ready <= 1'b1;
      end
    end
  end

  assign Dout     = r_dout;
  assign ready    = r_ready;
  assign i2c_stat = {r_done, 4'b0000, r_dnack, r_anack, r_busy};
  assign scl_oe   = w_scl_oe;
  assign sda_oe   = w_sda_oe;

endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core
//   Bench for i2c_master_core with a bus-level slave model. Expected bus
//   tokens (START, bytes, ACK bits, STOP) are queued when a transaction is
//   launched and popped as the monitor decodes them from SCL/SDA.
module tb_i2c_master_core;

  localparam int unsigned CLK_DIV = 4;

  localparam logic [11:0] T_START = 12'h200;
  localparam logic [11:0] T_STOP  = 12'h300;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  i2c_con1 = 8'h00;
  logic [7:0]  i2c_con2 = 8'h00;
  logic [31:0] Din = 32'h0;
  logic        sda_i;
  logic [31:0] Dout;
  logic        ready;
  logic [7:0]  i2c_stat;
  logic        scl_oe, sda_oe;

  logic        s_pull = 1'b0;
  logic        scl_line, sda_line;

  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | s_pull);
  assign sda_i    = sda_line;

  i2c_master_core #(.CLK_DIV(CLK_DIV)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .i2c_con1 (i2c_con1),
    .i2c_con2 (i2c_con2),
    .Din      (Din),
    .sda_i    (sda_i),
    .Dout     (Dout),
    .ready    (ready),
    .i2c_stat (i2c_stat),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [11:0] exp_q[$];

  task automatic got_tok(input logic [11:0] t);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check("bus_extra", 32'(t), 32'hFFF);
    end else begin
      e = exp_q.pop_front();
      check("bus_seq", 32'(t), 32'(e));
    end
  endtask

  // slave configuration
  logic       s_nack_addr = 1'b0;
  int         s_nack_byte = -1;
  logic [7:0] s_rdata[4];

  // protocol model: what a correct master and this slave put on the bus
  task automatic exp_txn(input logic [6:0] addr, input logic rw, input int n,
                         input logic [31:0] data, input logic addr_nack, input int nack_at);
    logic [7:0] b;
    logic       a;
    exp_q.push_back(T_START);
    exp_q.push_back({4'h1, addr, rw});
    exp_q.push_back({4'h4, 7'd0, addr_nack});
    if (!addr_nack) begin
      for (int k = 0; k < n; k++) begin
        b = rw ? s_rdata[k] : data[8*k +: 8];
        a = rw ? (k == n - 1) : (k == nack_at);
        exp_q.push_back({4'h1, b});
        exp_q.push_back({4'h4, 7'd0, a});
        if (!rw && (k == nack_at)) break;
      end
    end
    exp_q.push_back(T_STOP);
  endtask

  // bus monitor + slave
  int         m_bit = 0;
  int         m_nbyte = 0;
  int         n_start = 0;
  logic       m_active = 1'b0, m_rd = 1'b0, m_ack = 1'b1, m_drv = 1'b0;
  logic [7:0] m_sh = 8'h00;
  logic       p_scl = 1'b1, p_sda = 1'b1;

  always @(negedge PCLK) begin
    logic c_scl, c_sda;
    c_scl = scl_line;
    c_sda = sda_line;
    if (!PRESETn) begin
      m_active = 1'b0;
      m_bit    = 0;
      m_nbyte  = 0;
      s_pull   = 1'b0;
      p_scl    = 1'b1;
      p_sda    = 1'b1;
    end else begin
      if (c_scl && p_scl && p_sda && !c_sda) begin
        n_start++;
        m_active = 1'b1;
        m_bit    = 0;
        m_nbyte  = 0;
        m_rd     = 1'b0;
        m_drv    = 1'b0;
        s_pull   = 1'b0;
        got_tok(T_START);
      end else if (c_scl && p_scl && !p_sda && c_sda) begin
        m_active = 1'b0;
        s_pull   = 1'b0;
        got_tok(T_STOP);
      end else if (m_active && !p_scl && c_scl) begin
        if (m_bit < 8) m_sh = {m_sh[6:0], c_sda};
        else begin
          m_ack = c_sda;
          got_tok({4'h4, 7'd0, m_ack});
        end
        m_bit++;
      end else if (m_active && p_scl && !c_scl) begin
        if (m_bit == 8) begin
          got_tok({4'h1, m_sh});
          if (m_nbyte == 0) begin
            m_rd   = m_sh[0];
            s_pull = !s_nack_addr;
          end else if (m_rd) begin
            s_pull = 1'b0;
          end else begin
            s_pull = ((m_nbyte - 1) != s_nack_byte);
          end
        end else begin
          if (m_bit == 9) begin
            m_bit = 0;
            m_nbyte++;
            m_drv = !m_ack;
          end
          if (m_rd && m_drv && (m_nbyte > 0) && (m_nbyte <= 4))
            s_pull = !s_rdata[m_nbyte-1][7-m_bit];
          else
            s_pull = 1'b0;
        end
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  task automatic launch(input logic [7:0] c1, input logic [7:0] c2, input logic [31:0] d);
    @(negedge PCLK);
    i2c_con1 = c1;
    i2c_con2 = c2;
    Din      = d;
  endtask

  task automatic wait_done(output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge PCLK);
      if (i2c_stat[0]) busy_cyc++;
      if (i2c_stat[7] && !i2c_stat[0]) break;
    end
    check("done_seen", 32'(i2c_stat[7] & ~i2c_stat[0]), 32'h1);
  endtask

  task automatic post(input logic [7:0] stat, input logic [31:0] dout);
    check("stat", 32'(i2c_stat), 32'(stat));
    check("ready", 32'(ready), 32'h1);
    check("dout", Dout, dout);
    check("sb_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int bc;
    int n0;
    s_rdata[0] = 8'h12;
    s_rdata[1] = 8'h34;
    s_rdata[2] = 8'h56;
    s_rdata[3] = 8'h78;

    // reset state
    repeat (3) @(negedge PCLK);
    check("rst_dout", Dout, 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_stat", 32'(i2c_stat), 32'h0);
    check("rst_scl", 32'(scl_oe), 32'h0);
    check("rst_sda", 32'(sda_oe), 32'h0);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // write 1 byte
    exp_txn(7'h50, 1'b0, 1, 32'h000000A5, 1'b0, -1);
    launch(8'h01, 8'h50, 32'h000000A5);
    wait_done(bc);
    check("busy_w1", 32'(bc), 32'd321);
    post(8'h80, 32'h0);
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);

    // read 2 bytes
    exp_txn(7'h3C, 1'b1, 2, 32'h0, 1'b0, -1);
    launch(8'h07, 8'h3C, 32'hFFFFFFFF);
    wait_done(bc);
    post(8'h80, 32'h00003412);
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);

    // address NACK
    s_nack_addr = 1'b1;
    exp_txn(7'h2A, 1'b0, 4, 32'hDEADBEEF, 1'b1, -1);
    launch(8'h0D, 8'h2A, 32'hDEADBEEF);
    wait_done(bc);
    check("busy_anack", 32'(bc), 32'd177);
    post(8'h82, 32'h00003412);
    s_nack_addr = 1'b0;
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);

    // data NACK on byte 1 of 3
    s_nack_byte = 1;
    exp_txn(7'h21, 1'b0, 3, 32'h00332211, 1'b0, 1);
    launch(8'h09, 8'h21, 32'h00332211);
    wait_done(bc);
    check("busy_dnack", 32'(bc), 32'd465);
    post(8'h84, 32'h00003412);
    s_nack_byte = -1;
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);

    // go held high, Din changed mid-transfer, go edge while busy
    n0 = n_start;
    exp_txn(7'h11, 1'b0, 1, 32'h000000C3, 1'b0, -1);
    launch(8'h01, 8'h11, 32'h000000C3);
    repeat (100) @(negedge PCLK);
    Din = 32'h000000FF;
    i2c_con1 = 8'h00;
    repeat (2) @(negedge PCLK);
    i2c_con1 = 8'h01;
    wait_done(bc);
    post(8'h80, 32'h00003412);
    repeat (300) @(negedge PCLK);
    check("one_txn", 32'(n_start - n0), 32'd1);
    check("held_ready", 32'(ready), 32'h1);
    check("held_stat", 32'(i2c_stat), 32'h80);
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);
    n0 = n_start;
    exp_txn(7'h11, 1'b0, 1, 32'h0000005A, 1'b0, -1);
    launch(8'h01, 8'h11, 32'h0000005A);
    wait_done(bc);
    post(8'h80, 32'h00003412);
    check("second_txn", 32'(n_start - n0), 32'd1);
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);

    // reset during address bit 4
    exp_q.push_back(T_START);
    launch(8'h01, 8'h50, 32'h00000077);
    repeat (82) @(negedge PCLK);
    check("pre_rst_scl", 32'(scl_oe), 32'h1);
    check("pre_rst_sda", 32'(sda_oe), 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    check("async_scl", 32'(scl_oe), 32'h0);
    check("async_sda", 32'(sda_oe), 32'h0);
    i2c_con1 = 8'h00;
    @(negedge PCLK);
    check("mid_rst_dout", Dout, 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h1);
    check("mid_rst_stat", 32'(i2c_stat), 32'h0);
    check("mid_rst_sb", 32'(exp_q.size()), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    exp_txn(7'h50, 1'b0, 1, 32'h0000003C, 1'b0, -1);
    launch(8'h01, 8'h50, 32'h0000003C);
    wait_done(bc);
    check("busy_post_rst", 32'(bc), 32'd321);
    post(8'h80, 32'h0);
    i2c_con1 = 8'h00;
    repeat (4) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
